// File: rtl/cpu_pkg.sv
// Shared core constants: canonical zero word, NOP encodings and memory-op codes.
package cpu_pkg;

  localparam logic [31:0] ZERO_WORD    = 32'h0;
  localparam logic [4:0]  NOP_REG_ADDR = 5'd0;
  localparam logic [3:0]  MEM_NOP_OP   = 4'h0;
  localparam logic [3:0]  MEM_LW_OP    = 4'h1;
  localparam logic [3:0]  MEM_SW_OP    = 4'h5;

endpackage

// File: rtl/exe_mem_pipe_reg_if.sv
// EXE->MEM stage bundle: EXE-side instruction fields and control in, MEM-side registered copies out.
interface exe_mem_pipe_reg_if #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MEM_OP_W   = 4,
  parameter int unsigned REG_ADDR_W = 5
);

  logic                  exe_valid;
  logic [XLEN-1:0]       exe_pc;
  logic                  exe_we;
  logic [REG_ADDR_W-1:0] exe_write_reg;
  logic [XLEN-1:0]       exe_write_data;
  logic [MEM_OP_W-1:0]   exe_mem_op;
  logic [XLEN-1:0]       exe_mem_addr;
  logic [XLEN-1:0]       exe_mem_data;
  logic                  stall;
  logic                  flush;

  logic                  mem_valid;
  logic [XLEN-1:0]       mem_pc;
  logic                  mem_we;
  logic [REG_ADDR_W-1:0] mem_write_reg;
  logic [XLEN-1:0]       mem_write_data;
  logic [MEM_OP_W-1:0]   mem_mem_op;
  logic [XLEN-1:0]       mem_mem_addr;
  logic [XLEN-1:0]       mem_mem_data;

  modport master (
    output exe_valid, exe_pc, exe_we, exe_write_reg, exe_write_data,
    output exe_mem_op, exe_mem_addr, exe_mem_data, stall, flush,
    input  mem_valid, mem_pc, mem_we, mem_write_reg, mem_write_data,
    input  mem_mem_op, mem_mem_addr, mem_mem_data
  );

  modport slave (
    input  exe_valid, exe_pc, exe_we, exe_write_reg, exe_write_data,
    input  exe_mem_op, exe_mem_addr, exe_mem_data, stall, flush,
    output mem_valid, mem_pc, mem_we, mem_write_reg, mem_write_data,
    output mem_mem_op, mem_mem_addr, mem_mem_data
  );

endinterface

// File: rtl/store_history_buf.sv
// Circular history of the last SB_DEPTH stores with a combinational newest-match-wins lookup
// on word address (byte offset ignored).
module store_history_buf #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned SB_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cap_en_i,
  input  logic [XLEN-1:0]             cap_addr_i,
  input  logic [XLEN-1:0]             cap_data_i,
  input  logic [XLEN-1:0]             fwd_addr_i,
  output logic                        fwd_hit_o,
  output logic [XLEN-1:0]             fwd_data_o,
  output logic [$clog2(SB_DEPTH):0]   count_o
);

  localparam int unsigned PtrW = $clog2(SB_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned TagW = XLEN - 2;

  logic [SB_DEPTH-1:0] valid_q, valid_d;
  logic [TagW-1:0]     tag_q  [SB_DEPTH];
  logic [TagW-1:0]     tag_d  [SB_DEPTH];
  logic [XLEN-1:0]     data_q [SB_DEPTH];
  logic [XLEN-1:0]     data_d [SB_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]     count_q, count_d;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{cap_addr_i[1:0], fwd_addr_i[1:0]};

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    data_d   = data_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (cap_en_i) begin
      // When full, wr_ptr already points at the oldest entry, so it is overwritten.
      valid_d[wr_ptr_q] = 1'b1;
      tag_d[wr_ptr_q]   = cap_addr_i[XLEN-1:2];
      data_d[wr_ptr_q]  = cap_data_i;
      wr_ptr_d          = wr_ptr_q + PtrW'(1);
      count_d           = (count_q == CntW'(SB_DEPTH)) ? count_q : count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  // Scan oldest to newest so the newest match is the last to win.
  always_comb begin
    logic [PtrW-1:0] idx;
    idx        = '0;
    fwd_hit_o  = 1'b0;
    fwd_data_o = '0;
    for (int k = SB_DEPTH - 1; k >= 0; k--) begin
      idx = wr_ptr_q - PtrW'(k + 1);
      if (valid_q[idx] && (tag_q[idx] == fwd_addr_i[XLEN-1:2])) begin
        fwd_hit_o  = 1'b1;
        fwd_data_o = data_q[idx];
      end
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/exe_mem_pipe_reg.sv
// EXE->MEM pipeline register with flush/stall bubble control, store history for
// store-to-load forwarding, and the registered last captured store.
module exe_mem_pipe_reg
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MEM_OP_W   = 4,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned SB_DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  exe_mem_pipe_reg_if.slave         bus,
  input  logic [XLEN-1:0]           fwd_addr,
  output logic                      fwd_hit,
  output logic [XLEN-1:0]           fwd_data,
  output logic [XLEN-1:0]           last_store_addr,
  output logic [XLEN-1:0]           last_store_data,
  output logic [$clog2(SB_DEPTH):0] sb_count
);

  logic                  valid_q, valid_d;
  logic [XLEN-1:0]       pc_q, pc_d;
  logic                  we_q, we_d;
  logic [REG_ADDR_W-1:0] write_reg_q, write_reg_d;
  logic [XLEN-1:0]       write_data_q, write_data_d;
  logic [MEM_OP_W-1:0]   mem_op_q, mem_op_d;
  logic [XLEN-1:0]       mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]       mem_data_q, mem_data_d;
  logic [XLEN-1:0]       ls_addr_q, ls_addr_d;
  logic [XLEN-1:0]       ls_data_q, ls_data_d;
  logic                  store_cap;

  assign store_cap = !bus.flush && !bus.stall && bus.exe_valid &&
                     (bus.exe_mem_op == MEM_OP_W'(MEM_SW_OP));

  always_comb begin
    valid_d      = valid_q;
    pc_d         = pc_q;
    we_d         = we_q;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    mem_op_d     = mem_op_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    if (bus.flush) begin
      valid_d      = 1'b0;
      pc_d         = '0;
      we_d         = 1'b0;
      write_reg_d  = '0;
      write_data_d = '0;
      mem_op_d     = MEM_OP_W'(MEM_NOP_OP);
      mem_addr_d   = '0;
      mem_data_d   = '0;
    end else if (!bus.stall) begin
      valid_d      = bus.exe_valid;
      pc_d         = bus.exe_pc;
      we_d         = bus.exe_we;
      write_reg_d  = bus.exe_write_reg;
      write_data_d = bus.exe_write_data;
      mem_op_d     = bus.exe_mem_op;
      mem_addr_d   = bus.exe_mem_addr;
      mem_data_d   = bus.exe_mem_data;
      // A dead slot must never write the register file or touch memory.
      if (!bus.exe_valid) begin
        we_d     = 1'b0;
        mem_op_d = MEM_OP_W'(MEM_NOP_OP);
      end
    end
  end

  always_comb begin
    ls_addr_d = ls_addr_q;
    ls_data_d = ls_data_q;
    if (store_cap) begin
      ls_addr_d = bus.exe_mem_addr;
      ls_data_d = bus.exe_mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      pc_q         <= '0;
      we_q         <= 1'b0;
      write_reg_q  <= REG_ADDR_W'(NOP_REG_ADDR);
      write_data_q <= '0;
      mem_op_q     <= MEM_OP_W'(MEM_NOP_OP);
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      ls_addr_q    <= '0;
      ls_data_q    <= '0;
    end else begin
      valid_q      <= valid_d;
      pc_q         <= pc_d;
      we_q         <= we_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      mem_op_q     <= mem_op_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      ls_addr_q    <= ls_addr_d;
      ls_data_q    <= ls_data_d;
    end
  end

  store_history_buf #(
    .XLEN     (XLEN),
    .SB_DEPTH (SB_DEPTH)
  ) u_hist (
    .clk        (clk),
    .rst        (rst),
    .cap_en_i   (store_cap),
    .cap_addr_i (bus.exe_mem_addr),
    .cap_data_i (bus.exe_mem_data),
    .fwd_addr_i (fwd_addr),
    .fwd_hit_o  (fwd_hit),
    .fwd_data_o (fwd_data),
    .count_o    (sb_count)
  );

  assign bus.mem_valid      = valid_q;
  assign bus.mem_pc         = pc_q;
  assign bus.mem_we         = we_q;
  assign bus.mem_write_reg  = write_reg_q;
  assign bus.mem_write_data = write_data_q;
  assign bus.mem_mem_op     = mem_op_q;
  assign bus.mem_mem_addr   = mem_addr_q;
  assign bus.mem_mem_data   = mem_data_q;
  assign last_store_addr    = ls_addr_q;
  assign last_store_data    = ls_data_q;

endmodule

// File: doc/exe_mem_pipe_reg.md
Name: exe_mem_pipe_reg

Overview:
Parametrised, clocked EXE→MEM pipeline register with a valid bit, stall/flush control and bubble insertion. It also holds a small circular store-history buffer (last SB_DEPTH stores), searched combinationally for store-to-load forwarding, plus the registered last-store address/data. It sits between the EXE stage and the data-memory stage of the 5-stage core.

Parameters:
XLEN, 32, datapath/address width
MEM_OP_W, 4, memory-op code width
REG_ADDR_W, 5, register-file address width
SB_DEPTH, 4, store-history entries; power of two, ≥2

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
exe_valid  in  1  EXE slot holds a live instruction
exe_pc  in  XLEN  instruction PC
exe_we  in  1  register write enable
exe_write_reg  in  REG_ADDR_W  destination register
exe_write_data  in  XLEN  ALU result
exe_mem_op  in  MEM_OP_W  memory op code
exe_mem_addr  in  XLEN  effective address
exe_mem_data  in  XLEN  store data
stall  in  1  hold MEM-stage contents
flush  in  1  kill the EXE instruction; insert a bubble
mem_valid  out  1  MEM slot live
mem_pc, mem_mem_op, mem_mem_addr, mem_mem_data, mem_we, mem_write_reg, mem_write_data  out  (widths as exe_*)  registered copies
fwd_addr  in  XLEN  load address to look up
fwd_hit  out  1  a history entry matches fwd_addr
fwd_data  out  XLEN  data of the newest matching entry
last_store_addr  out  XLEN  address of the most recent captured store
last_store_data  out  XLEN  data of the most recent captured store
sb_count  out  $clog2(SB_DEPTH)+1  number of valid history entries

Behaviour:
- All state updates on posedge clk. Priority per cycle: rst > flush > stall > load.
- rst: mem_valid=0, mem_we=0, mem_mem_op=MEM_NOP_OP, mem_write_reg=NOP_REG_ADDR; all other mem_* =0. All history entries invalid, wr_ptr=0, sb_count=0, last_store_*=0. A reset asserted mid-stall or mid-flush still clears everything.
- flush: bubble. mem_valid=0, mem_we=0, mem_mem_op=MEM_NOP_OP, mem_write_reg=0, other mem_* =0. No history capture. Flush overrides stall.
- stall (no flush): every mem_* output, the history, wr_ptr and last_store_* hold their values.
- load: every mem_* output takes its exe_* value; mem_valid=exe_valid. If exe_valid=0, force mem_we=0 and mem_mem_op=MEM_NOP_OP.
- Store capture happens only on a load cycle with exe_valid=1 and exe_mem_op==MEM_SW_OP:
  - entry[wr_ptr] <= {valid=1, addr, data}; wr_ptr <= wr_ptr+1 (wraps modulo SB_DEPTH).
  - sb_count increments and saturates at SB_DEPTH; when full, the oldest entry is overwritten.
  - last_store_addr/data <= exe_mem_addr/exe_mem_data (both fields, updated in the same cycle).
  - Otherwise last_store_* holds.
- Forwarding lookup is combinational and has zero latency:
  - Compare fwd_addr[XLEN-1:2] against entry.addr[XLEN-1:2] for every valid entry.
  - The newest match wins (priority from wr_ptr-1 back to wr_ptr-SB_DEPTH, modulo SB_DEPTH).
  - No match: fwd_hit=0, fwd_data=0.
  - A store being captured in the current cycle is visible only from the next cycle (no same-cycle bypass).
- Latency: one cycle from exe_* to mem_*.

Decomposition:
- Package cpu_pkg holds ZERO_WORD (32'h0), NOP_REG_ADDR (5'd0), MEM_NOP_OP (4'h0), MEM_LW_OP (4'h1) and MEM_SW_OP (4'h5).
- Sub-module store_history_buf contains the circular entries, wr_ptr, count and the priority-match logic.
- The top module holds the pipeline register and the control priority.

Test Plan:
- rst=1 for 2 cycles with random exe_* → all mem_* =0, mem_mem_op=0, mem_valid=0, sb_count=0, fwd_hit=0 for any fwd_addr.
- Valid ALU op (pc=0x100, we=1, reg=5, data=0xAB) → appears on mem_* one cycle later; stall=1 for 3 cycles while exe_* changes → mem_* stays at 0x100/5/0xAB.
- SW addr=0x40, data=0x11 with flush=1 and stall=1 together → bubble (mem_valid=0, mem_we=0); sb_count=0; last_store_*=0.
- SW 0x40/0x11, then SW 0x40/0x22 → fwd_addr=0x42 gives fwd_hit=1, fwd_data=0x22 (newest wins, byte offset ignored); last_store=0x40/0x22.
- Six SWs to 0x0,0x4,…,0x14 (data = index) with SB_DEPTH=4 → sb_count=4; fwd_addr=0x0 and 0x4 miss; fwd_addr=0x14 hits with data 5.
- SW with exe_valid=0 → no capture, mem_mem_op=MEM_NOP_OP; on the SW capture cycle, fwd_addr=that address → fwd_hit=0, then 1 on the next cycle.
